exp_max_sequencer: RTL and testbench
====================================

EXP_MAX_SEQUENCER -- requirements
Module: exp_max_sequencer

Interface
REQ-001 Parameter expWidth, default 4, exponent field width in bits.
REQ-002 Parameter BLOCK_LEN, default 8, number of 4-exponent beats per block; legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_exp carries a valid beat.
REQ-006 in_ready  output  1  sequencer accepts a beat this cycle.
REQ-007 in_exp  input  expWidth*4  four unsigned exponents; lane k at bits [expWidth*(k+1)-1 : expWidth*k].
REQ-008 flush  input  1  close the current partial block early.
REQ-009 out_valid  output  1  out_exp holds a completed block maximum.
REQ-010 out_ready  input  1  consumer accepts out_exp.
REQ-011 out_exp  output  expWidth  unsigned maximum exponent of the block.
REQ-012 out_cnt  output  8  number of beats in the emitted block, minus one.
REQ-013 busy  output  1  high when at least one beat of the current block is accumulated, or in HOLD.

Function
REQ-014 The block SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 A beat is accepted when in_valid and in_ready are both 1; beat_max = unsigned max of the four in_exp lanes, computed combinationally.
REQ-016 On an accept with beat count 0, acc SHALL load beat_max; otherwise acc SHALL load max(acc, beat_max). Ties are don't-care, since equal values yield the same result.
REQ-017 The beat counter SHALL increment on each accept. When the accept is beat BLOCK_LEN-1, the state SHALL move to HOLD on the same edge, with out_exp = final max and out_cnt = BLOCK_LEN-1.
REQ-018 Latency: out_valid SHALL rise exactly 1 cycle after the final beat is accepted.
REQ-019 In HOLD, out_exp and out_cnt SHALL remain stable until out_valid and out_ready are both 1. On that edge the state SHALL return to ACCUM and the counter SHALL clear. The next beat SHALL NOT be accepted in that same cycle.
REQ-020 flush in ACCUM with counter > 0 SHALL move the state to HOLD and emit the partial block, with out_cnt = counter-1.
REQ-021 flush asserted together with an accepted beat SHALL include that beat, then emit.
REQ-022 flush in ACCUM with counter 0 and no accept SHALL be ignored.
REQ-023 flush in HOLD SHALL be ignored.
REQ-024 in_valid in HOLD SHALL be back-pressured: no state change occurs and the beat is not lost.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 While rst_n=0 the block SHALL be in ACCUM with counter=0, acc=0, out_exp=0, out_cnt=0, out_valid=0, busy=0, in_ready=0.
REQ-027 in_ready SHALL go to 1 on the first rising edge after rst_n deasserts.
REQ-028 Reset asserted mid-block or in HOLD SHALL discard all partial and pending results without emitting them.

Configuration
REQ-029 Macro EXP_MAX_SPECIAL_FLAG_EN, when defined, SHALL add output out_special (1 bit). out_special is 1 when any accepted lane in the block equals all-ones (Inf/NaN exponent).
REQ-030 out_special SHALL be registered alongside out_exp, held in HOLD, and reset to 0.
REQ-031 Without EXP_MAX_SPECIAL_FLAG_EN the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package exp_sched_pkg SHALL hold the state encoding (ACCUM=0, HOLD=1) and the counter width constant CNT_W=8.
REQ-033 The 4-to-1 unsigned max SHALL be one instance of the team's exp_comparison tree. A single expWidth comparator SHALL merge beat_max into acc.

Verification
REQ-034 expWidth=4, BLOCK_LEN=4, beats 0x1234,0x0005,0x7000,0x0302, out_ready=1 -> out_valid 1 cycle after beat 4, out_exp=7, out_cnt=3.
REQ-035 Same stream with out_ready=0 for 5 cycles -> out_exp stable at 7, in_ready=0 throughout, and the 5th beat is accepted only after the cycle following the out handshake.
REQ-036 Two beats 0x2222,0x4111, then flush with the third beat 0x0009 -> out_exp=9, out_cnt=2.
REQ-037 flush alone at counter 0 -> no out_valid. rst_n pulsed low after 2 beats -> no output, and the next full block's max excludes the pre-reset beats.
REQ-038 EXP_MAX_SPECIAL_FLAG_EN defined, a lane equal to 0xF in beat 2 -> out_exp=15, out_special=1; the next block of all-0x3 -> out_special=0.

Source files
------------

// File: rtl/exp_max_sequencer_pkg.sv
// rtl/exp_max_sequencer_pkg.sv - shared state encoding and counter width for the block-max sequencer
package exp_sched_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } seq_state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/exp_max_sequencer_if.sv
// rtl/exp_max_sequencer_if.sv - beat in / block-max out bundle; out_special exists only with EXP_MAX_SPECIAL_FLAG_EN
interface exp_max_sequencer_if #(
   parameter int expWidth = 4
);
   import exp_sched_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [expWidth*4-1:0] in_exp;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [expWidth-1:0]   out_exp;
   logic [CNT_W-1:0]      out_cnt;
   logic                  busy;
`ifdef EXP_MAX_SPECIAL_FLAG_EN
   logic                  out_special;

   modport master (
      output in_valid, in_exp, flush, out_ready,
      input  in_ready, out_valid, out_exp, out_cnt, busy, out_special
   );

   modport slave (
      input  in_valid, in_exp, flush, out_ready,
      output in_ready, out_valid, out_exp, out_cnt, busy, out_special
   );
`else
   modport master (
      output in_valid, in_exp, flush, out_ready,
      input  in_ready, out_valid, out_exp, out_cnt, busy
   );

   modport slave (
      input  in_valid, in_exp, flush, out_ready,
      output in_ready, out_valid, out_exp, out_cnt, busy
   );
`endif

endinterface

// File: rtl/exp_max_sequencer_cmp.sv
// rtl/exp_max_sequencer_cmp.sv - exp_comparison: two-level unsigned max tree over four exponent lanes
module exp_comparison #(
   parameter int W = 4
) (
   input  logic [4*W-1:0] lanes,
   output logic [W-1:0]   max_val
);

   logic [W-1:0] l0, l1, l2, l3;
   logic [W-1:0] m01, m23;

   assign l0 = lanes[W-1:0];
   assign l1 = lanes[2*W-1:W];
   assign l2 = lanes[3*W-1:2*W];
   assign l3 = lanes[4*W-1:3*W];

   assign m01     = (l1 > l0) ? l1 : l0;
   assign m23     = (l3 > l2) ? l3 : l2;
   assign max_val = (m23 > m01) ? m23 : m01;

endmodule

// File: rtl/exp_max_sequencer.sv
// rtl/exp_max_sequencer.sv - accumulates per-block max exponent and holds it until consumed
// Optional out_special tracking is enabled by EXP_MAX_SPECIAL_FLAG_EN.
module exp_max_sequencer
   import exp_sched_pkg::*;
#(
   parameter int expWidth  = 4,
   parameter int BLOCK_LEN = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   exp_max_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_LEN - 1);

   seq_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [expWidth-1:0] acc;
   logic [expWidth-1:0] beat_max;
   logic [expWidth-1:0] acc_next;
   logic                in_ready_q;
   logic                out_valid_q;
   logic [expWidth-1:0] out_exp_q;
   logic [CNT_W-1:0]    out_cnt_q;
   logic                accept;
   logic                close;

   exp_comparison #(.W(expWidth)) u_beat_max (
      .lanes   (bus.in_exp),
      .max_val (beat_max)
   );

   // in_ready_q is only ever high in ACCUM, so it alone qualifies the accept
   assign accept   = bus.in_valid && in_ready_q;
   assign acc_next = (cnt == '0) ? beat_max : ((beat_max > acc) ? beat_max : acc);
   assign close    = (state == ACCUM) &&
                     ((accept && (cnt == LAST_BEAT || bus.flush)) ||
                      (!accept && bus.flush && cnt != '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ACCUM;
         cnt         <= '0;
         acc         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_exp_q   <= '0;
         out_cnt_q   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  cnt <= cnt + 1'b1;
                  acc <= acc_next;
               end
               if (close) begin
                  state       <= HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_exp_q   <= accept ? acc_next : acc;
                  out_cnt_q   <= accept ? cnt : cnt - 1'b1;
               end
            end
            HOLD: begin
               // ready rises on the handshake edge, so the next beat lands a cycle later
               if (bus.out_ready) begin
                  state       <= ACCUM;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  cnt         <= '0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_exp   = out_exp_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.busy      = (state == HOLD) || (cnt != '0);

`ifdef EXP_MAX_SPECIAL_FLAG_EN
   logic spec_acc;
   logic beat_special;
   logic spec_next;
   logic out_special_q;

   // all-ones exponent marks Inf/NaN in any lane
   always_comb begin
      beat_special = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (bus.in_exp[k*expWidth +: expWidth] == {expWidth{1'b1}}) begin
            beat_special = 1'b1;
         end
      end
   end

   assign spec_next = (cnt == '0) ? beat_special : (spec_acc || beat_special);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spec_acc      <= 1'b0;
         out_special_q <= 1'b0;
      end else if (state == ACCUM) begin
         if (accept) begin
            spec_acc <= spec_next;
         end
         if (close) begin
            out_special_q <= accept ? spec_next : spec_acc;
         end
      end
   end

   assign bus.out_special = out_special_q;
`endif

endmodule

// File: tb/tb_exp_max_sequencer.sv
// tb/tb_exp_max_sequencer.sv - directed and random checks of exp_max_sequencer against a block-level model
module tb_exp_max_sequencer;
   localparam int EW = 4;
   localparam int BL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   exp_max_sequencer_if #(.expWidth(EW)) bus ();

   exp_max_sequencer #(.expWidth(EW), .BLOCK_LEN(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [15:0] m_beats[$];
   bit          m_pend  = 1'b0;
   bit          m_ready = 1'b0;
   int          m_max, m_cnt, m_spec;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic close_block();
      logic [15:0] b;
      m_max  = 0;
      m_spec = 0;
      foreach (m_beats[i]) begin
         b = m_beats[i];
         for (int k = 0; k < 4; k++) begin
            if (int'(b[k*4 +: 4]) > m_max) m_max = int'(b[k*4 +: 4]);
            if (b[k*4 +: 4] == 4'hF) m_spec = 1;
         end
      end
      m_cnt  = m_beats.size() - 1;
      m_pend = 1'b1;
      m_beats.delete();
   endtask

   task automatic step(input bit v, input logic [15:0] d, input bit fl, input bit ordy, output bit acc);
      @(negedge clk);
      check("in_ready", 32'(bus.in_ready), 32'(m_ready));
      check("out_valid", 32'(bus.out_valid), 32'(m_pend));
      check("busy", 32'(bus.busy), 32'((m_beats.size() > 0) || m_pend));
      if (m_pend) begin
         check("out_exp", 32'(bus.out_exp), 32'(m_max));
         check("out_cnt", 32'(bus.out_cnt), 32'(m_cnt));
`ifdef EXP_MAX_SPECIAL_FLAG_EN
         check("out_special", 32'(bus.out_special), 32'(m_spec));
`endif
      end
      bus.in_valid  = v;
      bus.in_exp    = d;
      bus.flush     = fl;
      bus.out_ready = ordy;
      acc = 1'b0;
      if (m_pend) begin
         if (ordy) begin
            m_pend  = 1'b0;
            m_ready = 1'b1;
         end
      end else begin
         if (v && m_ready) begin
            m_beats.push_back(d);
            acc = 1'b1;
         end
         if (m_beats.size() == BL || (fl && m_beats.size() > 0)) begin
            close_block();
            m_ready = 1'b0;
         end else begin
            m_ready = 1'b1;
         end
      end
   endtask

   task automatic beat(input logic [15:0] d, input bit fl, input bit ordy);
      bit a;
      step(1'b1, d, fl, ordy, a);
   endtask

   task automatic idle(input bit fl, input bit ordy);
      bit a;
      step(1'b0, 16'h0, fl, ordy, a);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_exp    = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      m_pend  = 1'b0;
      m_ready = 1'b0;
      m_beats.delete();
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_exp", 32'(bus.out_exp), 32'd0);
      check("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(bus.in_ready), 32'd0);
      m_ready = 1'b1;
   endtask

   bit          hv;
   logic [15:0] hd;
   bit          a;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_exp    = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      do_reset(2);

      // full block, immediate consume
      beat(16'h1234, 0, 1); beat(16'h0005, 0, 1); beat(16'h7000, 0, 1); beat(16'h0302, 0, 1);
      settle();
      check("d1_valid", 32'(bus.out_valid), 32'd1);
      check("d1_exp", 32'(bus.out_exp), 32'd7);
      check("d1_cnt", 32'(bus.out_cnt), 32'd3);
      idle(0, 1);

      // consumer stalls 5 cycles while a 5th beat is offered
      beat(16'h1234, 0, 0); beat(16'h0005, 0, 0); beat(16'h7000, 0, 0); beat(16'h0302, 0, 0);
      repeat (5) beat(16'h0abc, 0, 0);
      settle();
      check("d2_hold_exp", 32'(bus.out_exp), 32'd7);
      check("d2_hold_ready", 32'(bus.in_ready), 32'd0);
      beat(16'h0abc, 0, 1);
      settle();
      check("d2_after_hs_ready", 32'(bus.in_ready), 32'd1);
      check("d2_after_hs_busy", 32'(bus.busy), 32'd0);
      step(1'b1, 16'h0abc, 0, 0, a);
      check("d2_5th_accepted", 32'(a), 32'd1);
      idle(1, 1);
      idle(0, 1);

      // flush together with the third beat
      beat(16'h2222, 0, 0); beat(16'h4111, 0, 0); beat(16'h0009, 1, 0);
      settle();
      check("d3_exp", 32'(bus.out_exp), 32'd9);
      check("d3_cnt", 32'(bus.out_cnt), 32'd2);
      idle(1, 1);

      // flush at count 0, then reset mid-block
      idle(1, 1);
      settle();
      check("d4_no_valid", 32'(bus.out_valid), 32'd0);
      beat(16'h00ee, 0, 1); beat(16'h0dd0, 0, 1);
      do_reset(1);
      beat(16'h1111, 0, 1); beat(16'h2222, 0, 1); beat(16'h1313, 0, 1); beat(16'h0102, 0, 1);
      settle();
      check("d4_exp", 32'(bus.out_exp), 32'd3);
      idle(0, 1);

`ifdef EXP_MAX_SPECIAL_FLAG_EN
      beat(16'h1111, 0, 1); beat(16'h21f1, 0, 1); beat(16'h0000, 0, 1); beat(16'h0123, 0, 1);
      settle();
      check("d5_exp", 32'(bus.out_exp), 32'd15);
      check("d5_special", 32'(bus.out_special), 32'd1);
      idle(0, 1);
      repeat (4) beat(16'h3333, 0, 1);
      settle();
      check("d5_exp2", 32'(bus.out_exp), 32'd3);
      check("d5_special2", 32'(bus.out_special), 32'd0);
      idle(0, 1);
`endif

      // random traffic with held beats, flushes, stalls and occasional reset
      hv = 1'b0;
      hd = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset($urandom_range(1, 3));
            hv = 1'b0;
         end else begin
            if (!hv && $urandom_range(0, 3) != 0) begin
               hv = 1'b1;
               hd = 16'($urandom);
               if ($urandom_range(0, 15) == 0) hd[4*$urandom_range(0, 3) +: 4] = 4'hF;
            end
            step(hv, hd, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, a);
            if (a) hv = 1'b0;
         end
      end
      idle(0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
